fetch_sequencer: RTL and testbench

- Instruction-fetch controller that owns the program counter for the 16-bit datapath.
- Drives the read address of the byte-addressed instruction memory (one 16-bit word per 2 bytes, combinational read) and captures the returned word into an IF/ID register.
- Handles start, stall, branch/jump redirect, halt detection, address wrap and out-of-range fault.
- Sits between instruction memory and the decode stage.

---
 rtl/fetch_sequencer.sv | 93 +++++++++
 tb/tb_fetch_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, drives imem_addr, captures the IF/ID register.
// Optional MISALIGN_TRAP_EN: an odd redirect target faults instead of being force-aligned.
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          IMEM_BYTES = 60,
  parameter logic [15:0] HALT_WORD  = 16'hEFFF,
  parameter logic [15:0] NOP_WORD   = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_addr,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic        if_valid,
  output logic        halted,
  output logic        fetch_err,
  output logic [15:0] fetch_count
);
  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_RUN  = 2'd1;
  localparam logic [1:0]  S_HALT = 2'd2;
  localparam logic [16:0] LIMIT  = 17'(IMEM_BYTES);

  logic [1:0]  state;
  logic [15:0] pc;
  logic [16:0] pc_inc;
  logic        bad_target;

  // 17-bit increment so the wrap test cannot be fooled by 16-bit overflow
  assign pc_inc    = {1'b0, pc} + 17'd2;
  assign imem_addr = pc;

  always_comb begin
    bad_target = ({1'b0, redirect_addr} >= LIMIT);
`ifdef MISALIGN_TRAP_EN
    bad_target = bad_target | redirect_addr[0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      if_instr    <= NOP_WORD;
      if_pc       <= 16'h0000;
      if_valid    <= 1'b0;
      halted      <= 1'b0;
      fetch_err   <= 1'b0;
      fetch_count <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            pc    <= RESET_PC;
          end
        end
        S_RUN: begin
          if (redirect_valid) begin
            if_valid <= 1'b0;
            if_instr <= NOP_WORD;
            if (bad_target) begin
              state     <= S_HALT;
              fetch_err <= 1'b1;
            end else begin
              pc <= {redirect_addr[15:1], 1'b0};
            end
          end else if (!stall) begin
            if_instr <= imem_data;
            if_pc    <= pc;
            if_valid <= 1'b1;
            if (fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
            // a halt word is kept in IF/ID; pc stays pointing at it
            if (imem_data == HALT_WORD) state <= S_HALT;
            else if (pc_inc >= LIMIT)   pc    <= 16'h0000;
            else                        pc    <= pc_inc[15:0];
          end
        end
        S_HALT: begin
          halted   <= 1'b1;
          if_valid <= 1'b0;
          if_instr <= NOP_WORD;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed + randomized bench for fetch_sequencer against a behavioural fetch model.
module tb_fetch_sequencer;
  localparam logic [15:0] HALT = 16'hEFFF;
  localparam int          MEMB = 60;

  logic        clk = 1'b0;
  logic        reset, start, stall, redirect_valid;
  logic [15:0] redirect_addr, imem_addr, imem_data, if_instr, if_pc, fetch_count;
  logic        if_valid, halted, fetch_err;

  logic [15:0] mem [0:29];
  int tests = 0, fails = 0;

  // model state: phase 0 idle, 1 fetching, 2 stopped
  int          m_phase;
  logic [15:0] m_pc, m_instr, m_ifpc, m_cnt;
  logic        m_valid, m_halted, m_err;

  always #5 clk = ~clk;

  always_comb begin
    if (imem_addr[15:1] < 16'd30) imem_data = mem[imem_addr[15:1]];
    else                          imem_data = 16'h0000;
  end

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_addr(imem_addr), .imem_data(imem_data), .if_instr(if_instr),
    .if_pc(if_pc), .if_valid(if_valid), .halted(halted),
    .fetch_err(fetch_err), .fetch_count(fetch_count)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic target_faults(input logic [15:0] a);
    logic f;
    f = (int'(a) >= MEMB);
`ifdef MISALIGN_TRAP_EN
    if (a % 2 == 1) f = 1'b1;
`endif
    return f;
  endfunction

  task automatic model_edge();
    logic [15:0] w;
    if (!reset) begin
      m_phase = 0; m_pc = 0; m_instr = 0; m_ifpc = 0;
      m_valid = 0; m_halted = 0; m_err = 0; m_cnt = 0;
    end else if (m_phase == 0) begin
      if (start) begin m_phase = 1; m_pc = 0; end
    end else if (m_phase == 1) begin
      if (redirect_valid) begin
        m_valid = 0; m_instr = 0;
        if (target_faults(redirect_addr)) begin m_phase = 2; m_err = 1; end
        else m_pc = redirect_addr - (redirect_addr % 2);
      end else if (!stall) begin
        w = mem[m_pc / 2];
        m_instr = w; m_ifpc = m_pc; m_valid = 1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
        if (w == HALT) m_phase = 2;
        else if (int'(m_pc) + 2 >= MEMB) m_pc = 0;
        else m_pc = m_pc + 2;
      end
    end else begin
      m_halted = 1; m_valid = 0; m_instr = 0;
    end
  endtask

  task automatic check_all();
    chk("imem_addr", imem_addr, m_pc);
    chk("if_instr", if_instr, m_instr);
    chk("if_pc", if_pc, m_ifpc);
    chk("if_valid", {15'd0, if_valid}, {15'd0, m_valid});
    chk("halted", {15'd0, halted}, {15'd0, m_halted});
    chk("fetch_err", {15'd0, fetch_err}, {15'd0, m_err});
    chk("fetch_count", fetch_count, m_cnt);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic r, input logic s, input logic st, input logic rv,
                       input logic [15:0] ra);
    reset = r; start = s; stall = st; redirect_valid = rv; redirect_addr = ra;
  endtask

  task automatic fill_mem(input int halt_odds);
    for (int i = 0; i < 30; i++) begin
      mem[i] = 16'($urandom);
      if (mem[i] == HALT) mem[i] = 16'h1234;
      if (halt_odds > 0 && $urandom_range(0, halt_odds - 1) == 0) mem[i] = HALT;
    end
  endtask

  initial begin
    int n;
    fill_mem(0);
    mem[0] = 16'h0120; mem[1] = 16'h0121; mem[2] = 16'h0AE2; mem[25] = HALT;
    drive(0, 0, 0, 0, 0);
    step();
    chk("rst_instr", if_instr, 16'h0000);
    chk("rst_count", fetch_count, 16'h0000);

    // start and three sequential fetches
    drive(1, 1, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0); step();
    chk("f0_instr", if_instr, 16'h0120); chk("f0_addr", imem_addr, 16'd2);
    step(); chk("f1_instr", if_instr, 16'h0121); chk("f1_pc", if_pc, 16'd2);
    step(); chk("f2_instr", if_instr, 16'h0AE2); chk("f2_cnt", fetch_count, 16'd3);

    // stall at pc 6
    drive(1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin step(); chk("stall_addr", imem_addr, 16'd6); end
    chk("stall_cnt", fetch_count, 16'd3);
    drive(1, 0, 0, 0, 0); step(); chk("resume_pc", if_pc, 16'd6);

    // redirect wins over stall
    drive(1, 0, 1, 1, 16'h0018); step();
    chk("redir_valid", {15'd0, if_valid}, 16'd0); chk("redir_addr", imem_addr, 16'h0018);
    drive(1, 0, 0, 0, 0); step(); chk("redir_ifpc", if_pc, 16'h0018);

    // run into the halt word at 0x32
    n = 0;
    while (imem_addr != 16'h0032 && n < 40) begin step(); n++; end
    chk("reach_halt_budget", {15'd0, n < 40}, 16'd1);
    step();
    chk("halt_instr", if_instr, HALT); chk("halt_valid", {15'd0, if_valid}, 16'd1);
    drive(1, 1, 0, 1, 16'h0000);
    step(); chk("halted", {15'd0, halted}, 16'd1); chk("halt_pc", imem_addr, 16'h0032);
    step();

    // wrap and out-of-range redirect
    drive(0, 0, 0, 0, 0); step();
    drive(1, 1, 0, 0, 0); step();
    drive(1, 0, 0, 1, 16'h003A); step();
    drive(1, 0, 0, 0, 0); step(); chk("wrap_pc", imem_addr, 16'h0000);
    drive(1, 0, 0, 1, 16'h003C); step(); chk("oor_err", {15'd0, fetch_err}, 16'd1);
    drive(1, 0, 0, 0, 0); step(); chk("oor_halted", {15'd0, halted}, 16'd1);

    // odd redirect target
    drive(0, 0, 0, 0, 0); step();
    drive(1, 1, 0, 0, 0); step();
    drive(1, 0, 0, 1, 16'h0013); step();
`ifndef MISALIGN_TRAP_EN
    chk("align_pc", imem_addr, 16'h0012);
`endif
    drive(1, 0, 0, 0, 0); step();
`ifdef MISALIGN_TRAP_EN
    chk("mis_err", {15'd0, fetch_err}, 16'd1); chk("mis_halted", {15'd0, halted}, 16'd1);
`endif

    // reset mid-run
    drive(1, 0, 0, 0, 0); step(); step();
    drive(0, 0, 0, 0, 0); step();
    chk("mid_rst_valid", {15'd0, if_valid}, 16'd0); chk("mid_rst_cnt", fetch_count, 16'd0);

    // randomized episodes
    for (int e = 0; e < 20; e++) begin
      fill_mem(40);
      drive(0, 0, 0, 0, 0); step();
      for (int c = 0; c < 150; c++) begin
        drive($urandom_range(0, 99) >= 2, $urandom_range(0, 9) == 0,
              $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0,
              16'($urandom_range(0, 70)));
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
